// File: rtl/riscv_pipe_skid_register_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pipe_skid_register_pkg
//   Shared types for the pipeline skid register.
//   - OCC_W   : width of the occupancy output (0..2 entries)
//   - xfer_t  : per-cycle handshake summary (accept / emit)
// -----------------------------------------------------------------------------
package riscv_pipe_skid_register_pkg;

    localparam int OCC_W = 2;

    typedef struct packed {
        logic accept;   // i_valid && o_ready
        logic emit;     // o_valid && i_ready
    } xfer_t;

    function automatic xfer_t make_xfer(input logic valid_in, input logic ready_out,
                                        input logic valid_out, input logic ready_in);
        xfer_t x;
        x.accept = valid_in & ready_out;
        x.emit   = valid_out & ready_in;
        return x;
    endfunction

endpackage

// File: rtl/riscv_pipe_slot.sv
// -----------------------------------------------------------------------------
// riscv_pipe_slot
//   Load-enable storage register with synchronous initialisation.
//   Ports:
//     i_clk   - clock, rising edge
//     i_rstn  - synchronous active-low reset, loads INIT
//     i_init  - synchronous flush, loads INIT
//     i_load  - capture i_d
//     i_d     - data in  [W-1:0]
//     o_q     - data out [W-1:0]
// -----------------------------------------------------------------------------
module riscv_pipe_slot #(
    parameter int          W    = 32,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_init,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge i_clk) begin
        if (!i_rstn || i_init) begin
            o_q <= INIT;
        end else if (i_load) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/riscv_pipe_skid_register.sv
// -----------------------------------------------------------------------------
// riscv_pipe_skid_register
//   Two-entry (main + skid) valid/ready pipeline stage. All outputs come from
//   registers, so i_ready never reaches o_ready combinationally.
//   Ports:
//     i_clk, i_rstn       - clock, synchronous active-low reset
//     i_clr               - synchronous flush of state and data
//     i_valid/o_ready     - upstream handshake
//     i_data              - NUM_CH channels, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//     o_valid/i_ready     - downstream handshake
//     o_data              - main entry, same layout as i_data
//     o_count             - occupancy 0..2
//     o_stall_cnt         - saturating count of o_valid && !i_ready cycles
// -----------------------------------------------------------------------------
// XLEN normally comes from riscv_configs.v; fall back to 32 when it is absent.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_pipe_skid_register
    import riscv_pipe_skid_register_pkg::*;
#(
    parameter int                    DATA_WIDTH    = `XLEN,
    parameter int                    NUM_CH        = 3,
    parameter logic [DATA_WIDTH-1:0] REGISTER_INIT = '0,
    parameter int                    CNT_WIDTH     = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic                         i_clr,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_data,
    output logic [OCC_W-1:0]             o_count,
    output logic [CNT_WIDTH-1:0]         o_stall_cnt
);

    localparam int                 BUS_W    = NUM_CH * DATA_WIDTH;
    localparam logic [BUS_W-1:0]   BUS_INIT = {NUM_CH{REGISTER_INIT}};

    // Encodings equal the occupancy so o_count is the state register itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    xfer_t             xfer;
    logic              main_load, skid_load;
    logic [BUS_W-1:0]  main_d, main_q, skid_q;
    logic [CNT_WIDTH-1:0] stall_q;

    assign o_valid = (state_q != EMPTY);
    assign o_ready = (state_q != FULL);
    assign o_count = OCC_W'(state_q);
    assign o_data  = main_q;
    assign o_stall_cnt = stall_q;

    assign xfer = make_xfer(i_valid, o_ready, o_valid, i_ready);

    always_ff @(posedge i_clk) begin
        if (!i_rstn || i_clr) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = i_data;
        unique case (state_q)
            EMPTY: begin
                if (xfer.accept) begin
                    main_load = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (xfer.accept && !xfer.emit) begin
                    skid_load = 1'b1;
                    state_d   = FULL;
                end else if (xfer.accept && xfer.emit) begin
                    main_load = 1'b1;
                end else if (xfer.emit) begin
                    state_d   = EMPTY;
                end
            end
            FULL: begin
                // o_ready is low here, so accept can never be set.
                if (xfer.emit) begin
                    main_d    = skid_q;
                    main_load = 1'b1;
                    state_d   = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    riscv_pipe_slot #(.W(BUS_W), .INIT(BUS_INIT)) u_main (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_init (i_clr),
        .i_load (main_load),
        .i_d    (main_d),
        .o_q    (main_q)
    );

    riscv_pipe_slot #(.W(BUS_W), .INIT(BUS_INIT)) u_skid (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_init (i_clr),
        .i_load (skid_load),
        .i_d    (i_data),
        .o_q    (skid_q)
    );

    // Flush leaves the stall counter alone; only reset clears it.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            stall_q <= '0;
        end else if (o_valid && !i_ready && !(&stall_q)) begin
            stall_q <= stall_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_riscv_pipe_skid_register.sv
module tb_riscv_pipe_skid_register;

    localparam int DW     = 8;
    localparam int NCH    = 3;
    localparam int CW     = 4;
    localparam int BW     = DW * NCH;
    localparam logic [DW-1:0] INIT = 8'hA5;
    localparam logic [BW-1:0] INIT_BUS = 24'hA5A5A5;

    logic          i_clk;
    logic          i_rstn;
    logic          i_clr;
    logic          i_valid;
    logic          o_ready;
    logic [BW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [BW-1:0] o_data;
    logic [1:0]    o_count;
    logic [CW-1:0] o_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [BW-1:0] sb[$];

    riscv_pipe_skid_register #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .REGISTER_INIT(INIT), .CNT_WIDTH(CW)
    ) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_clr(i_clr),
        .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_count(o_count), .o_stall_cnt(o_stall_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        tick();
        tick();
        i_rstn = 1'b1;
        sb.delete();
    endtask

    // Monitor: an emit happens at the next edge when o_valid && i_ready,
    // unless reset or flush overrides it.
    always @(negedge i_clk) begin
        if (i_rstn && !i_clr && o_valid && i_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL emit_unexpected: got %0h expected no output", o_data);
            end else begin
                logic [BW-1:0] exp;
                exp = sb.pop_front();
                if (o_data !== exp) begin
                    n_fail++;
                    $display("FAIL emit_data: got %0h expected %0h", o_data, exp);
                end
            end
        end
    end

    initial begin
        i_rstn  = 1'b0;
        i_clr   = 1'b0;
        i_valid = 1'b1;
        i_ready = 1'b0;
        i_data  = 24'hDEAD01;

        // Reset held 2 cycles with i_valid high.
        tick();
        tick();
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_data",  64'(o_data),  64'(INIT_BUS));
        check("rst_stall", 64'(o_stall_cnt), 64'd0);
        i_valid = 1'b0;
        i_rstn  = 1'b1;
        sb.delete();
        tick();

        // Streaming at full rate.
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data = 24'h111111; sb.push_back(24'h111111); tick();
        check("stream_lat_valid", 64'(o_valid), 64'd1);
        check("stream_data1", 64'(o_data), 64'h111111);
        check("stream_cnt1", 64'(o_count), 64'd1);
        i_data = 24'h222222; sb.push_back(24'h222222); tick();
        check("stream_cnt2", 64'(o_count), 64'd1);
        i_data = 24'h333333; sb.push_back(24'h333333); tick();
        check("stream_cnt3", 64'(o_count), 64'd1);
        check("stream_data3", 64'(o_data), 64'h333333);
        i_valid = 1'b0; tick();
        check("stream_drain", 64'(o_count), 64'd0);

        // Backpressure: A, B fill the stage, C waits.
        do_reset();
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data = 24'h030201; sb.push_back(24'h030201); tick();
        check("bp_cnt_a", 64'(o_count), 64'd1);
        i_data = 24'h060504; sb.push_back(24'h060504); tick();
        check("bp_cnt_full", 64'(o_count), 64'd2);
        check("bp_ready_full", 64'(o_ready), 64'd0);
        check("bp_data_a", 64'(o_data), 64'h030201);
        i_data = 24'h090807; sb.push_back(24'h090807); tick();
        check("bp_cnt_hold", 64'(o_count), 64'd2);
        check("bp_data_hold", 64'(o_data), 64'h030201);
        tick();
        check("bp_stall", 64'(o_stall_cnt), 64'd3);
        i_ready = 1'b1; tick();
        check("bp_cnt_after_a", 64'(o_count), 64'd1);
        check("bp_data_b", 64'(o_data), 64'h060504);
        check("bp_ready_busy", 64'(o_ready), 64'd1);
        tick();
        check("bp_data_c", 64'(o_data), 64'h090807);
        i_valid = 1'b0; tick();
        check("bp_drain", 64'(o_count), 64'd0);

        // Flush while FULL, with accept and emit both requested.
        do_reset();
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data = 24'h0D0C0B; sb.push_back(24'h0D0C0B); tick();
        i_data = 24'h100F0E; sb.push_back(24'h100F0E); tick();
        check("fl_full", 64'(o_count), 64'd2);
        i_clr   = 1'b1;
        i_ready = 1'b1;
        i_data  = 24'h131211;
        sb.delete();
        tick();
        check("fl_valid", 64'(o_valid), 64'd0);
        check("fl_count", 64'(o_count), 64'd0);
        check("fl_ready", 64'(o_ready), 64'd1);
        check("fl_data",  64'(o_data),  64'(INIT_BUS));
        check("fl_stall_kept", 64'(o_stall_cnt), 64'd1);
        i_clr   = 1'b0;
        i_valid = 1'b0;
        tick();
        tick();
        check("fl_idle", 64'(o_valid), 64'd0);

        // Stall counter saturation.
        do_reset();
        i_ready = 1'b0;
        i_valid = 1'b0;
        tick(); tick(); tick();
        check("sat_idle", 64'(o_stall_cnt), 64'd0);
        i_valid = 1'b1;
        i_data = 24'h171615; sb.push_back(24'h171615); tick();
        i_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("sat_10", 64'(o_stall_cnt), 64'd10);
        for (int i = 0; i < 10; i++) tick();
        check("sat_top", 64'(o_stall_cnt), 64'd15);
        for (int i = 0; i < 5; i++) tick();
        check("sat_hold", 64'(o_stall_cnt), 64'd15);
        i_ready = 1'b1; tick();
        check("sat_drain", 64'(o_count), 64'd0);
        check("sat_after", 64'(o_stall_cnt), 64'd15);

        // Reset while FULL.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data = 24'h1A1918; sb.push_back(24'h1A1918); tick();
        i_data = 24'h1D1C1B; sb.push_back(24'h1D1C1B); tick();
        check("mr_full", 64'(o_count), 64'd2);
        i_rstn = 1'b0;
        sb.delete();
        tick();
        check("mr_count", 64'(o_count), 64'd0);
        check("mr_valid", 64'(o_valid), 64'd0);
        check("mr_ready", 64'(o_ready), 64'd1);
        check("mr_stall", 64'(o_stall_cnt), 64'd0);
        check("mr_data",  64'(o_data),  64'(INIT_BUS));
        i_rstn  = 1'b1;
        i_valid = 1'b0;
        tick();
        tick();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
